// File: rtl/CC_ITF_PKG.sv
`default_nettype none
// ============================================================================
// Package     : CC_ITF_PKG
// Description : Shared core-complex interface types. Holds the 32-bit APB
//               request/response structs, the APB initiator state encoding,
//               the default APB window constants and the responder-decode
//               helper used by cc_apb_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package CC_ITF_PKG;

  // Default APB window: responder i sits at BASE + i * 2**SIZE_LOG2.
  localparam logic [31:0] APB_BASE_ADDR_DEF     = 32'h1000_0000;
  localparam int unsigned APB_SLV_SIZE_LOG2_DEF = 12;

  // Width of a stored responder index; supports up to 256 responders.
  localparam int unsigned APB_IDX_W = 8;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_d32_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_d32_resps_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_init_state_e;

  typedef struct packed {
    logic                 hit;
    logic [APB_IDX_W-1:0] idx;
  } apb_dec_t;

  // Maps a byte address onto a responder index. A miss is reported for
  // addresses below the window, beyond the last responder, or not
  // word aligned. The explicit below-base test is needed because the
  // subtraction would otherwise wrap into a large, possibly valid, offset.
  function automatic apb_dec_t apb_decode(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned size_log2,
                                          input int unsigned num_slv);
    logic [31:0] off;
    logic [31:0] idx32;
    apb_dec_t    d;
    off   = addr - base;
    idx32 = off >> size_log2;
    d.idx = idx32[APB_IDX_W-1:0];
    d.hit = (addr >= base) && (idx32 < num_slv) && (addr[1:0] == 2'b00);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : cc_apb_initiator
// Description : Single-outstanding APB initiator for the core-complex
//               peripheral bus. Accepts 32-bit load/store requests on a
//               valid/ready front end, decodes the target responder and runs
//               the APB SETUP/ACCESS sequence, returning read data and an
//               error flag on a valid/ready response channel.
// Options     : SOPHON_APB_TIMEOUT_EN - when defined, an ACCESS phase that
//               sees no pready for TIMEOUT_CYC cycles is abandoned with err=1.
// Ports       : clk_i, rst_i (async, active high)
//               req_valid_i/req_ready_o, req_addr_i, req_we_i, req_wdata_i,
//               req_be_i                          - request channel
//               rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_err_o
//                                                 - response channel
//               apb_req_o[NUM_SLV], apb_rsp_i[NUM_SLV] - APB responder ports
// Revision    : 1.0 - initial release
// ============================================================================
module cc_apb_initiator
  import CC_ITF_PKG::*;
#(
  parameter int unsigned NUM_SLV       = 3,
  parameter logic [31:0] BASE_ADDR     = APB_BASE_ADDR_DEF,
  parameter int unsigned SLV_SIZE_LOG2 = APB_SLV_SIZE_LOG2_DEF,
  parameter int unsigned TIMEOUT_CYC   = 256
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [31:0]    req_addr_i,
  input  logic           req_we_i,
  input  logic [31:0]    req_wdata_i,
  input  logic [3:0]     req_be_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_rdata_o,
  output logic           rsp_err_o,
  output apb_d32_req_t   apb_req_o [NUM_SLV],
  input  apb_d32_resps_t apb_rsp_i [NUM_SLV]
);

  apb_init_state_e      state_q, state_d;
  logic                 ready_q, ready_d;
  logic [APB_IDX_W-1:0] idx_q,   idx_d;
  logic [31:0]          addr_q,  addr_d;
  logic                 we_q,    we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           strb_q,  strb_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q,   err_d;

  apb_dec_t             dec;
  apb_d32_resps_t       sel_rsp;

`ifdef SOPHON_APB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
`endif

  assign dec = apb_decode(req_addr_i, BASE_ADDR, SLV_SIZE_LOG2, NUM_SLV);

  // Response of the responder currently addressed by the latched index.
  always_comb begin
    sel_rsp = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (idx_q == APB_IDX_W'(i)) begin
        sel_rsp = apb_rsp_i[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef SOPHON_APB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          rdata_d = '0;
          if (dec.hit) begin
            // Transfer fields are latched only for legal targets so that a
            // rejected request leaves every APB signal untouched.
            idx_d   = dec.idx;
            addr_d  = req_addr_i;
            we_d    = req_we_i;
            wdata_d = req_we_i ? req_wdata_i : 32'h0;
            strb_d  = req_we_i ? req_be_i    : 4'h0;
            err_d   = 1'b0;
            state_d = ST_SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_SETUP: begin
`ifdef SOPHON_APB_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (sel_rsp.pready) begin
          // Writes and failed reads return zero data.
          rdata_d = (we_q || sel_rsp.pslverr) ? 32'h0 : sel_rsp.prdata;
          err_d   = sel_rsp.pslverr;
          state_d = ST_RESP;
        end
`ifdef SOPHON_APB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is registered so it is low throughout reset and rises in the
    // first IDLE cycle.
    ready_d = (state_d == ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef SOPHON_APB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, no input feed-through.
  // --------------------------------------------------------------------------
  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  for (genvar i = 0; i < int'(NUM_SLV); i++) begin : g_port
    logic sel;
    assign sel = (idx_q == APB_IDX_W'(i)) &&
                 ((state_q == ST_SETUP) || (state_q == ST_ACCESS));
    assign apb_req_o[i] = '{
      paddr:   addr_q,
      pprot:   3'b000,
      psel:    sel,
      penable: sel && (state_q == ST_ACCESS),
      pwrite:  we_q,
      pwdata:  wdata_q,
      pstrb:   strb_q
    };
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_apb_initiator
// Description : Directed self-checking bench for cc_apb_initiator. Covers
//               reset state, a zero-wait read, a write with wait states,
//               decode/alignment errors, pslverr with response back-pressure,
//               the access timeout (or indefinite wait without it) and an
//               asynchronous reset during ACCESS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_apb_initiator;
  import CC_ITF_PKG::*;

  localparam int NS = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic           req_we;
  logic [31:0]    req_wdata;
  logic [3:0]     req_be;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
  apb_d32_req_t   apb_req [NS];
  apb_d32_resps_t apb_rsp [NS];

  int n_chk  = 0;
  int n_pass = 0;

  cc_apb_initiator #(
    .NUM_SLV      (NS),
    .BASE_ADDR    (32'h1000_0000),
    .SLV_SIZE_LOG2(12),
    .TIMEOUT_CYC  (8)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_we_i   (req_we),
    .req_wdata_i(req_wdata),
    .req_be_i   (req_be),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .apb_req_o  (apb_req),
    .apb_rsp_i  (apb_rsp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] psel_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i] = apb_req[i].psel;
    return v;
  endfunction

  function automatic logic [31:0] pen_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i] = apb_req[i].penable;
    return v;
  endfunction

  task automatic send(input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    req_be    = be;
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NS; i++) apb_rsp[i] = '{pready: 1'b1, prdata: 32'h0, pslverr: 1'b0};

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_ready", {31'b0, req_ready}, 32'h0);
    check("rst_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err",   {31'b0, rsp_err}, 32'h0);
    check("rst_psel",  psel_vec(), 32'h0);
    check("rst_paddr", apb_req[1].paddr, 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_ready", {31'b0, req_ready}, 32'h1);

    // ---------------- read, zero wait ----------------
    apb_rsp[1] = '{pready: 1'b1, prdata: 32'hA5A5_0001, pslverr: 1'b0};
    send(32'h1000_1004, 1'b0, 32'h0, 4'hF);            // cycle 0
    step(); req_valid = 1'b0;                          // cycle 1
    check("rd_c1_psel",  psel_vec(), 32'h2);
    check("rd_c1_pen",   pen_vec(),  32'h0);
    check("rd_c1_paddr", apb_req[1].paddr, 32'h1000_1004);
    check("rd_c1_pstrb", {28'b0, apb_req[1].pstrb}, 32'h0);
    step();                                            // cycle 2
    check("rd_c2_pen",   pen_vec(),  32'h2);
    check("rd_c2_valid", {31'b0, rsp_valid}, 32'h0);
    step();                                            // cycle 3
    check("rd_c3_valid", {31'b0, rsp_valid}, 32'h1);
    check("rd_c3_rdata", rsp_rdata, 32'hA5A5_0001);
    check("rd_c3_err",   {31'b0, rsp_err}, 32'h0);
    check("rd_c3_psel",  psel_vec(), 32'h0);
    step();
    check("rd_idle_ready", {31'b0, req_ready}, 32'h1);

    // ---------------- write with 3 wait states ----------------
    apb_rsp[0] = '{pready: 1'b0, prdata: 32'hFFFF_FFFF, pslverr: 1'b0};
    send(32'h1000_0008, 1'b1, 32'h1234_5678, 4'b0011); // cycle 0
    step(); req_valid = 1'b0;                          // cycle 1
    check("wr_c1_psel", psel_vec(), 32'h1);
    check("wr_c1_pwrite", {31'b0, apb_req[0].pwrite}, 32'h1);
    for (int c = 2; c <= 4; c++) begin
      step();
      check("wr_wait_pen",   pen_vec(), 32'h1);
      check("wr_wait_pstrb", {28'b0, apb_req[0].pstrb}, 32'h3);
      check("wr_wait_pwdata", apb_req[0].pwdata, 32'h1234_5678);
      check("wr_wait_valid", {31'b0, rsp_valid}, 32'h0);
    end
    step();                                            // cycle 5
    check("wr_c5_pen", pen_vec(), 32'h1);
    apb_rsp[0].pready = 1'b1;
    step();                                            // cycle 6
    check("wr_c6_valid", {31'b0, rsp_valid}, 32'h1);
    check("wr_c6_rdata", rsp_rdata, 32'h0);
    check("wr_c6_err",   {31'b0, rsp_err}, 32'h0);
    step();

    // ---------------- decode / alignment errors ----------------
    send(32'h1000_3000, 1'b0, 32'h0, 4'hF);
    step(); req_valid = 1'b0;
    check("dec_c1_valid", {31'b0, rsp_valid}, 32'h1);
    check("dec_c1_err",   {31'b0, rsp_err}, 32'h1);
    check("dec_c1_psel",  psel_vec(), 32'h0);
    step();
    send(32'h1000_0002, 1'b0, 32'h0, 4'hF);
    step(); req_valid = 1'b0;
    check("aln_c1_valid", {31'b0, rsp_valid}, 32'h1);
    check("aln_c1_err",   {31'b0, rsp_err}, 32'h1);
    check("aln_c1_psel",  psel_vec(), 32'h0);
    check("aln_paddr_kept", apb_req[0].paddr, 32'h1000_0008);
    step();
    send(32'h0FFF_FFFC, 1'b0, 32'h0, 4'hF);
    step(); req_valid = 1'b0;
    check("low_c1_err",  {31'b0, rsp_err}, 32'h1);
    check("low_c1_psel", psel_vec(), 32'h0);
    step();

    // ---------------- pslverr + response back-pressure ----------------
    rsp_ready  = 1'b0;
    apb_rsp[2] = '{pready: 1'b1, prdata: 32'h5555_AAAA, pslverr: 1'b1};
    send(32'h1000_2010, 1'b0, 32'h0, 4'hF);            // cycle 0
    step(); req_valid = 1'b0;                          // cycle 1
    check("slv_c1_psel", psel_vec(), 32'h4);
    step();                                            // cycle 2
    step();                                            // cycle 3
    check("slv_c3_valid", {31'b0, rsp_valid}, 32'h1);
    check("slv_c3_err",   {31'b0, rsp_err}, 32'h1);
    check("slv_c3_rdata", rsp_rdata, 32'h0);
    apb_rsp[0] = '{pready: 1'b1, prdata: 32'hDEAD_BEEF, pslverr: 1'b0};
    send(32'h1000_0000, 1'b0, 32'h0, 4'hF);
    step();                                            // cycle 4
    check("slv_hold_ready", {31'b0, req_ready}, 32'h0);
    check("slv_hold_valid", {31'b0, rsp_valid}, 32'h1);
    check("slv_hold_psel",  psel_vec(), 32'h0);
    rsp_ready = 1'b1;
    step();                                            // cycle 5: IDLE
    check("slv_idle_ready", {31'b0, req_ready}, 32'h1);
    check("slv_idle_valid", {31'b0, rsp_valid}, 32'h0);
    step(); req_valid = 1'b0;                          // SETUP of new read
    check("nx_psel", psel_vec(), 32'h1);
    step();
    step();
    check("nx_valid", {31'b0, rsp_valid}, 32'h1);
    check("nx_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("nx_err",   {31'b0, rsp_err}, 32'h0);
    step();

    // ---------------- timeout / indefinite wait ----------------
    apb_rsp[1] = '{pready: 1'b0, prdata: 32'h1111_2222, pslverr: 1'b0};
    send(32'h1000_1000, 1'b0, 32'h0, 4'hF);            // cycle 0
    step(); req_valid = 1'b0;                          // cycle 1
`ifdef SOPHON_APB_TIMEOUT_EN
    seen = 0;
    for (int c = 2; c <= 9; c++) begin                 // 8 ACCESS cycles
      step();
      if (rsp_valid || !apb_req[1].penable) seen++;
    end
    check("tmo_access_held", seen, 32'h0);
    step();                                            // cycle 10
    check("tmo_psel",  psel_vec(), 32'h0);
    check("tmo_valid", {31'b0, rsp_valid}, 32'h1);
    check("tmo_err",   {31'b0, rsp_err}, 32'h1);
    check("tmo_rdata", rsp_rdata, 32'h0);
    apb_rsp[1].pready = 1'b1;
    step();
`else
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("notmo_no_rsp", seen, 32'h0);
    check("notmo_psel",   psel_vec(), 32'h2);
    check("notmo_pen",    pen_vec(),  32'h2);
    apb_rsp[1].pready = 1'b1;
    step();
    check("notmo_valid", {31'b0, rsp_valid}, 32'h1);
    check("notmo_rdata", rsp_rdata, 32'h1111_2222);
    step();
`endif

    // ---------------- reset during ACCESS ----------------
    apb_rsp[0] = '{pready: 1'b0, prdata: 32'h0, pslverr: 1'b0};
    send(32'h1000_0004, 1'b0, 32'h0, 4'hF);            // cycle 0
    step(); req_valid = 1'b0;                          // cycle 1
    step();                                            // cycle 2: ACCESS
    check("ra_pen", pen_vec(), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("ra_psel",  psel_vec(), 32'h0);
    check("ra_valid", {31'b0, rsp_valid}, 32'h0);
    check("ra_ready", {31'b0, req_ready}, 32'h0);
    step();
    step();
    rst = 1'b0;
    apb_rsp[0] = '{pready: 1'b1, prdata: 32'h0BAD_F00D, pslverr: 1'b0};
    step();
    check("ra_post_ready", {31'b0, req_ready}, 32'h1);
    check("ra_post_valid", {31'b0, rsp_valid}, 32'h0);
    send(32'h1000_000C, 1'b0, 32'h0, 4'hF);
    step(); req_valid = 1'b0;
    check("ra_new_psel", psel_vec(), 32'h1);
    step();
    step();
    check("ra_new_valid", {31'b0, rsp_valid}, 32'h1);
    check("ra_new_rdata", rsp_rdata, 32'h0BAD_F00D);
    check("ra_new_err",   {31'b0, rsp_err}, 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cc_apb_initiator.md
# cc_apb_initiator

APB initiator for the core-complex peripheral bus: it accepts single-outstanding 32-bit load/store requests on a valid/ready front end and drives them as APB transfers to one of NUM_SLV APB responders. These are the syscfg register block, the UART and the external CLIC port. Address decode, APB SETUP/ACCESS sequencing, wait-state handling and error reporting live here. The block also supplies an optional access timeout so a hung responder cannot stall the requester.

## Interface
- NUM_SLV, default 3: number of APB responder ports.
- BASE_ADDR, default 32'h1000_0000: base of the APB window.
- SLV_SIZE_LOG2, default 12: each responder owns 2^SLV_SIZE_LOG2 bytes. Responder i occupies BASE_ADDR + i·2^SLV_SIZE_LOG2.
- TIMEOUT_CYC, default 256: ACCESS-phase cycle limit. Used only with the timeout feature.

- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = write.
- req_wdata_i  in  32  write data.
- req_be_i  in  4  byte enables, mapped to pstrb.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  decode, alignment, pslverr or timeout error.
- apb_req_o  out  NUM_SLV × CC_ITF_PKG::apb_d32_req_t  APB requests.
- apb_rsp_i  in  NUM_SLV × CC_ITF_PKG::apb_d32_resps_t  APB responses.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP. Reset forces IDLE.
- **IDLE**
  - req_ready_o=1.
  - On handshake, latch addr, we, wdata and be, then compute the slave index idx = (addr − BASE_ADDR) >> SLV_SIZE_LOG2.
  - If the address is below BASE_ADDR, idx ≥ NUM_SLV, or addr[1:0]≠0, go to RESP with err=1. No APB signal toggles.
  - Otherwise go to SETUP.
- **SETUP**
  - apb_req_o[idx].psel=1 and penable=0.
  - paddr is the full latched address. Also drive pwrite, pwdata and pstrb=be (0 for reads); pprot=3'b000.
  - Next state is ACCESS unconditionally.
- **ACCESS**
  - psel=1, penable=1, with all fields held stable.
  - On apb_rsp_i[idx].pready=1, capture prdata (reads only) and pslverr into rsp_err, deassert psel/penable, and go to RESP.
- **RESP**
  - rsp_valid_o=1 with rdata and err stable.
  - When rsp_ready_i=1, go to IDLE.
  - A new request is accepted only in the following IDLE cycle.
- psel is asserted on at most one port at a time. Non-selected ports always see psel=0 and penable=0.
- Reset values:
  - req_ready_o=0 while rst_i is asserted; 1 in the first IDLE cycle after release.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - All psel, penable, pwrite, paddr, pwdata and pstrb are 0.
- Reset asserted mid-transfer aborts it immediately: psel drops, the FSM goes to IDLE and the lost response is never issued.

## Timing
- Minimum latency, with pready=1 in the first ACCESS cycle:
  - Cycle 0: accept.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS.
  - Cycle 3: rsp_valid_o=1.
- Each pready=0 wait state adds one cycle.
- Decode or alignment errors: rsp_valid_o=1 at cycle 1.
- All outputs are registered; nothing has a combinational path from req_* or apb_rsp_i to apb_req_o.
- Throughput is one transfer per 4 cycles when rsp_ready_i is tied high.

## Configuration
- SOPHON_APB_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments on every ACCESS cycle with pready=0.
  - On the cycle the count reaches TIMEOUT_CYC−1 with pready still 0, psel/penable drop and the FSM enters RESP with err=1 and rdata=0.
  - A pready=1 arriving in that same cycle wins: it is a normal completion.
- SOPHON_APB_TIMEOUT_EN undefined: there is no counter, and ACCESS waits on pready indefinitely.

## Structure
- The decode helper function and the state enum go in CC_ITF_PKG, next to apb_d32_req_t and apb_d32_resps_t.
- The default BASE_ADDR and SLV_SIZE_LOG2 constants also go in CC_ITF_PKG.
- The block is a single module with no sub-module; the decode is a package function.

## Test plan
- Read with base 0x1000_0000: read 0x1000_1004, responder 1 pready=1 with prdata=0xA5A5_0001 → psel[1] at cycle 1, penable at cycle 2, rsp_valid at cycle 3, rdata=0xA5A5_0001, err=0.
- Write with wait states: write 0x1000_0008, data 0x1234_5678, be=4'b0011, responder 0 holds pready=0 for 3 cycles → pstrb=0011 and pwdata stable throughout, rsp_valid at cycle 6, rdata=0.
- Decode and alignment errors: reads at 0x1000_3000 and at 0x1000_0002 → rsp_valid at cycle 1 with err=1; no psel on any port.
- pslverr: pready=1 with pslverr=1 on responder 2 → err=1; the next request is accepted only after rsp_ready_i.
- Timeout: with SOPHON_APB_TIMEOUT_EN and TIMEOUT_CYC=8, pready is held 0 → psel drops after the 8th ACCESS cycle, err=1. Without the macro, the bench holds for 1000 cycles with no response.
- Reset mid-access: assert rst_i during ACCESS → psel=0 and rsp_valid=0 asynchronously; after release, req_ready_o=1 and a fresh read completes normally.
